mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single byte-wide memory port between the wasm parser/ROM loader (req 0)
//  and the cpu (req 1). Grants ownership through per-requester gnt lines; cpu mem_access is driven from gnt[1].
//  Muxes the owner's addr/data/strobes onto the memory and routes memory_ready back to the owner only.
//  Inserts a bus turnaround cycle between owners and aborts stalled transactions with a watchdog.
// PARAMETERS
//  ADDR_W      32    address width of requester and memory buses
//  TIMEOUT     255   max cycles an owner strobe may wait for mem_ready before abort (>=2)
//  CNT_W       8     width of watchdog counter; must hold TIMEOUT
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  req            in   2       bus request; [0]=parser, [1]=cpu; level, held for whole tenure
//  gnt            out  2       one-hot-or-zero bus grant; gnt[1] feeds cpu mem_access
//  p_addr/c_addr  in   ADDR_W  requester addresses (cpu side is z when not granted)
//  p_wdata/c_wdata in  8       requester write data
//  p_rd/c_rd      in   1       requester read strobe
//  p_wr/c_wr      in   1       requester write strobe
//  p_ready/c_ready out 1       memory_ready routed to owner; 0 for non-owner
//  mem_addr       out  ADDR_W  memory address
//  mem_wdata      out  8       memory data_in
//  mem_rd         out  1       memory_read_en
//  mem_wr         out  1       memory_write_en
//  mem_ready      in   1       memory_ready
//  timeout_err    out  1       sticky: a transaction was aborted by the watchdog
// BEHAVIOUR
//  Reset (async, immediate, also mid-transaction): state=IDLE, gnt=0, mem_rd=mem_wr=0,
//   mem_addr=0, mem_wdata=0, p_ready=c_ready=0, timeout_err=0, wdog=0, last_owner=1.
//  States: IDLE -> OWN -> TURN -> IDLE.
//  IDLE: if req!=0, register grant next edge (1-cycle grant latency) and go OWN.
//   Single requester wins. Both requesting: requester != last_owner wins (round robin;
//   parser wins first contest after reset). Load last_owner on grant.
//  OWN: mem_addr/mem_wdata/mem_rd/mem_wr combinationally follow the owner's inputs,
//   gated by gnt, so non-owner inputs (incl. x/z) never reach memory.
//   If owner rd and wr are both 1: mem_wr=1, mem_rd forced 0.
//   owner_ready = mem_ready, same cycle; non-owner ready = 0 always.
//   Owner req low at an edge -> TURN; gnt drops that edge. If mem_ready and the req drop
//   fall in the same cycle, the ready is still delivered in that cycle.
//  Watchdog: wdog increments each OWN cycle with owner (rd|wr)=1 and mem_ready=0;
//   clears on mem_ready=1, when strobes are low, or on leaving OWN. On reaching TIMEOUT:
//   set timeout_err, drop gnt, go TURN, even though req is still high.
//   The aborted owner may re-request after IDLE; timeout_err stays set until rst_n.
//  TURN: exactly one cycle; gnt=0, mem_rd=mem_wr=0, readies 0; then IDLE.
//   No requester is granted during TURN even if req is high. Back-to-back owners
//   therefore have >=2 cycles with gnt=0.
//  After abort, owner with req still high re-arbitrates normally; it stays subject to round robin.
//  No preemption: a requester holding req with no strobe active keeps the bus indefinitely.
//  mem_addr/mem_wdata hold their last driven value while idle (registered copy); strobes are 0.
//  Invariant: gnt never has both bits set; mem_rd&mem_wr never both 1.
// TESTING
//  1 reset then req=2'b01, p_rd=1 addr=0x10, mem_ready after 3 cycles -> gnt=01 one cycle
//    after req; mem_addr=0x10, mem_rd=1; p_ready pulses with mem_ready; c_ready stays 0.
//  2 req=2'b11 from IDLE after reset -> gnt=01; parser drops req -> one TURN cycle
//    with gnt=00, then gnt=10; next contest with both high -> gnt=01 again.
//  3 cpu owns, c_wr=1 c_wdata=0xA5 addr=0xAA while p_addr=0xFFFF_FFFF and p_wr=1 ->
//    mem_wr=1, mem_wdata=0xA5, mem_addr=0xAA; parser inputs never appear on mem_*.
//  4 TIMEOUT=4, parser owns, p_rd=1, mem_ready held 0 -> after 4 stalled cycles
//    timeout_err=1, gnt=00, TURN then IDLE; re-grant follows since req still high.
//  5 rst_n pulsed low mid-write with mem_wr=1 -> mem_wr, gnt, and readies are 0 immediately
//    without a clock edge; timeout_err cleared; first contest after release goes to parser.
//  6 owner with c_rd=c_wr=1 -> mem_wr=1, mem_rd=0; req drops in the mem_ready cycle ->
//    c_ready=1 that cycle, then gnt=00 with TURN.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin owner of the shared byte memory port with turnaround and stall watchdog
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [7:0]        p_wdata,
  input  logic [7:0]        c_wdata,
  input  logic              p_rd,
  input  logic              c_rd,
  input  logic              p_wr,
  input  logic              c_wr,
  output logic              p_ready,
  output logic              c_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
  state_t state, state_nxt;
  logic [1:0] gnt_nxt;
  logic last_owner, last_nxt;
  logic [CNT_W-1:0] wdog, wdog_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0] wdata_q;
  logic o_req, o_rd, o_wr, stall, abort;
  // Non-owner inputs (possibly x/z) are masked by gnt before reaching memory.
  assign o_req     = |(req & gnt);
  assign o_rd      = (gnt[0] & p_rd) | (gnt[1] & c_rd);
  assign o_wr      = (gnt[0] & p_wr) | (gnt[1] & c_wr);
  assign mem_addr  = gnt[1] ? c_addr : gnt[0] ? p_addr : addr_q;
  assign mem_wdata = gnt[1] ? c_wdata : gnt[0] ? p_wdata : wdata_q;
  assign mem_wr    = o_wr;
  assign mem_rd    = o_rd & ~o_wr;
  assign p_ready   = gnt[0] & mem_ready;
  assign c_ready   = gnt[1] & mem_ready;
  assign stall     = (o_rd | o_wr) & ~mem_ready;
  assign abort     = stall && (wdog == CNT_W'(TIMEOUT - 1));
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last_owner;
    wdog_nxt  = '0;
    case (state)
      IDLE: if (|req) begin
        state_nxt = OWN;
        gnt_nxt   = (req == 2'b11) ? (last_owner ? 2'b01 : 2'b10) : req;
        last_nxt  = (req == 2'b11) ? ~last_owner : req[1];
      end
      OWN: if (!o_req || abort) begin
        state_nxt = TURN;
        gnt_nxt   = 2'b00;
      end else begin
        wdog_nxt  = stall ? wdog + 1'b1 : '0;
      end
      TURN: state_nxt = IDLE;
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt         <= 2'b00;
      last_owner  <= 1'b1;
      wdog        <= '0;
      timeout_err <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      last_owner  <= last_nxt;
      wdog        <= wdog_nxt;
      timeout_err <= timeout_err | abort;
      addr_q      <= mem_addr;
      wdata_q     <= mem_wdata;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table vectors, hand-written corner sequences and random run against a tenure-level model
module tb_mem_bus_arbiter;
  localparam int TO = 4;
  logic clk = 0, rst_n = 1;
  logic [1:0] req = 0, gnt;
  logic [31:0] p_addr = 32'h10, c_addr = 32'hAA, mem_addr;
  logic [7:0] p_wdata = 8'h11, c_wdata = 8'h22, mem_wdata;
  logic p_rd = 0, c_rd = 0, p_wr = 0, c_wr = 0, mem_ready = 0;
  logic p_ready, c_ready, mem_rd, mem_wr, timeout_err;
  int errors = 0, checks = 0;

  mem_bus_arbiter #(.ADDR_W(32), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .p_addr(p_addr), .c_addr(c_addr), .p_wdata(p_wdata), .c_wdata(c_wdata),
    .p_rd(p_rd), .c_rd(c_rd), .p_wr(p_wr), .c_wr(c_wr),
    .p_ready(p_ready), .c_ready(c_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit rst;
    logic [1:0] req;
    logic prd, pwr, crd, cwr, rdy;
    logic [1:0] gnt;
    logic rd, wr, pr, cr;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, logic [1:0] rq, logic prd, logic pwr, logic crd, logic cwr,
                             logic rdy, logic [1:0] g, logic rd, logic wr, logic pr, logic cr,
                             logic [31:0] a);
    v = {rst, rq, prd, pwr, crd, cwr, rdy, g, rd, wr, pr, cr, a};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_inputs();
    req = 0; p_rd = 0; p_wr = 0; c_rd = 0; c_wr = 0; mem_ready = 0;
    p_addr = 32'h10; c_addr = 32'hAA; p_wdata = 8'h11; c_wdata = 8'h22;
  endtask

  task automatic pulse_reset();
    zero_inputs();
    rst_n = 0;
    #1;
    rst_n = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model state: tenure-level view of the bus
  int m_owner, m_gap, m_last, m_wait;
  bit m_err;
  logic [31:0] m_addr;
  logic [7:0] m_wd;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // round robin, turnaround, rd+wr priority, basic read
    tbl.push_back(v(1, 2'b11, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'h00));
    tbl.push_back(v(0, 2'b11, 0,0,0,0,0, 2'b01, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b10, 0,0,0,0,0, 2'b01, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b10, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b10, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b11, 0,0,0,0,0, 2'b10, 0,0,0,0, 32'hAA));
    tbl.push_back(v(0, 2'b01, 0,0,0,0,0, 2'b10, 0,0,0,0, 32'hAA));
    tbl.push_back(v(0, 2'b11, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'hAA));
    tbl.push_back(v(0, 2'b11, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'hAA));
    tbl.push_back(v(0, 2'b11, 0,0,0,0,0, 2'b01, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b10, 0,0,0,0,0, 2'b01, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b10, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b10, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b10, 0,0,1,1,0, 2'b10, 0,1,0,0, 32'hAA));
    tbl.push_back(v(0, 2'b00, 0,0,1,1,1, 2'b10, 0,1,0,1, 32'hAA));
    tbl.push_back(v(0, 2'b00, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'hAA));
    tbl.push_back(v(0, 2'b00, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'hAA));
    tbl.push_back(v(1, 2'b01, 1,0,0,0,0, 2'b00, 0,0,0,0, 32'h00));
    tbl.push_back(v(0, 2'b01, 1,0,0,0,0, 2'b01, 1,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b01, 1,0,0,0,0, 2'b01, 1,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b01, 1,0,0,0,1, 2'b01, 1,0,1,0, 32'h10));
    tbl.push_back(v(0, 2'b00, 0,0,0,0,0, 2'b01, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b00, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'h10));
    tbl.push_back(v(0, 2'b00, 0,0,0,0,0, 2'b00, 0,0,0,0, 32'h10));

    rst_n = 0;
    #2;
    rst_n = 1;
    next_cycle();
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_err", 32'(timeout_err), 0);
    chk("reset_addr", mem_addr, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      req = tbl[i].req; p_rd = tbl[i].prd; p_wr = tbl[i].pwr;
      c_rd = tbl[i].crd; c_wr = tbl[i].cwr; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("row%0d_rd", i), 32'(mem_rd), 32'(tbl[i].rd));
      chk($sformatf("row%0d_wr", i), 32'(mem_wr), 32'(tbl[i].wr));
      chk($sformatf("row%0d_pready", i), 32'(p_ready), 32'(tbl[i].pr));
      chk($sformatf("row%0d_cready", i), 32'(c_ready), 32'(tbl[i].cr));
      chk($sformatf("row%0d_addr", i), mem_addr, tbl[i].addr);
      next_cycle();
    end

    // cpu owns; parser garbage and cpu-side z must not reach memory
    pulse_reset();
    req = 2'b10; c_wr = 1; c_wdata = 8'hA5; c_addr = 'z;
    p_addr = 32'hFFFF_FFFF; p_wr = 1; p_rd = 1; p_wdata = 8'h5A; mem_ready = 1;
    #1;
    chk("iso_idle_wr", 32'(mem_wr), 0);
    chk("iso_idle_addr", mem_addr, 0);
    chk("iso_idle_wdata", 32'(mem_wdata), 0);
    chk("iso_idle_pready", 32'(p_ready), 0);
    next_cycle();
    c_addr = 32'hAA;
    #1;
    chk("iso_gnt", 32'(gnt), 2);
    chk("iso_wr", 32'(mem_wr), 1);
    chk("iso_rd", 32'(mem_rd), 0);
    chk("iso_wdata", 32'(mem_wdata), 32'hA5);
    chk("iso_addr", mem_addr, 32'hAA);
    chk("iso_cready", 32'(c_ready), 1);
    chk("iso_pready", 32'(p_ready), 0);
    next_cycle();

    // watchdog abort after TO stalled cycles, then re-grant
    pulse_reset();
    req = 2'b01; p_rd = 1; mem_ready = 0;
    #1;
    chk("wd_c0_gnt", 32'(gnt), 0);
    next_cycle();
    for (int k = 1; k <= TO; k++) begin
      chk($sformatf("wd_c%0d_gnt", k), 32'(gnt), 1);
      chk($sformatf("wd_c%0d_err", k), 32'(timeout_err), 0);
      next_cycle();
    end
    chk("wd_abort_gnt", 32'(gnt), 0);
    chk("wd_abort_err", 32'(timeout_err), 1);
    chk("wd_abort_rd", 32'(mem_rd), 0);
    next_cycle();
    chk("wd_idle_gnt", 32'(gnt), 0);
    next_cycle();
    chk("wd_regrant_gnt", 32'(gnt), 1);
    chk("wd_sticky_err", 32'(timeout_err), 1);

    // async reset mid-write
    p_rd = 0; p_wr = 1;
    #1;
    chk("ar_pre_wr", 32'(mem_wr), 1);
    mem_ready = 1;
    rst_n = 0;
    #1;
    chk("ar_wr", 32'(mem_wr), 0);
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_pready", 32'(p_ready), 0);
    chk("ar_err", 32'(timeout_err), 0);
    chk("ar_addr", mem_addr, 0);
    rst_n = 1; req = 2'b11; p_wr = 0; mem_ready = 0;
    next_cycle();
    chk("ar_first_contest", 32'(gnt), 1);
    next_cycle();

    // randomized run against the reference model
    pulse_reset();
    m_owner = -1; m_gap = 0; m_last = 1; m_wait = 0; m_err = 0; m_addr = 0; m_wd = 0;
    for (int n = 0; n < 600; n++) begin
      logic [1:0] eg;
      logic erd, ewr, epr, ecr, ord, owr;
      logic [31:0] ea;
      logic [7:0] ew;
      if ($urandom_range(5) == 0) req[0] = ~req[0];
      if ($urandom_range(5) == 0) req[1] = ~req[1];
      p_rd = 1'($urandom); p_wr = 1'($urandom); c_rd = 1'($urandom); c_wr = 1'($urandom);
      mem_ready = ($urandom_range(2) == 0);
      p_addr = $urandom; c_addr = $urandom; p_wdata = 8'($urandom); c_wdata = 8'($urandom);
      #1;
      ord = (m_owner == 0) ? p_rd : (m_owner == 1) ? c_rd : 1'b0;
      owr = (m_owner == 0) ? p_wr : (m_owner == 1) ? c_wr : 1'b0;
      eg  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
      ea  = (m_owner == 0) ? p_addr : (m_owner == 1) ? c_addr : m_addr;
      ew  = (m_owner == 0) ? p_wdata : (m_owner == 1) ? c_wdata : m_wd;
      ewr = owr;
      erd = ord && !owr;
      epr = (m_owner == 0) && mem_ready;
      ecr = (m_owner == 1) && mem_ready;
      checks++;
      if ({gnt, mem_rd, mem_wr, p_ready, c_ready, timeout_err, mem_addr, mem_wdata} !==
          {eg, erd, ewr, epr, ecr, m_err, ea, ew}) begin
        errors++;
        $display("FAIL rand%0d: got gnt=%b rd=%b wr=%b pr=%b cr=%b err=%b addr=%h wd=%h expected gnt=%b rd=%b wr=%b pr=%b cr=%b err=%b addr=%h wd=%h",
                 n, gnt, mem_rd, mem_wr, p_ready, c_ready, timeout_err, mem_addr, mem_wdata,
                 eg, erd, ewr, epr, ecr, m_err, ea, ew);
      end
      next_cycle();
      if (m_owner >= 0) begin
        m_addr = ea; m_wd = ew;
        m_wait = ((ord || owr) && !mem_ready) ? m_wait + 1 : 0;
        if (m_wait == TO) m_err = 1;
        if (!req[m_owner] || m_wait == TO) begin
          m_owner = -1; m_gap = 1; m_wait = 0;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (req != 0) begin
        m_owner = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
        m_last = m_owner;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n && ((gnt == 2'b11) || (mem_rd && mem_wr))) begin
      errors++;
      $display("FAIL invariant: gnt=%b rd=%b wr=%b required gnt not 11 and not rd&wr", gnt, mem_rd, mem_wr);
    end
  end
endmodule
